// File: rtl/updown_counter.sv
// Parametrised up/down counter with prescaled count enable, programmable step,
// synchronous clear/load and wrap-or-saturate limit handling with registered event flags.
module updown_counter #(
    parameter int                WIDTH       = 16,
    parameter logic [WIDTH-1:0]  MAX_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                PRESCALE    = 1,
    parameter bit                SATURATE    = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_value,
    output logic             o_tick,
    output logic             o_wrap,
    output logic             o_at_max,
    output logic             o_at_min
);

    // A single-bit prescaler is kept even for PRESCALE=1; it simply never leaves 0.
    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0]  LIMIT    = {1'b0, MAX_VALUE};
    localparam logic [WIDTH:0]  MODULUS  = LIMIT + (WIDTH+1)'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic             tick_q;
    logic             tick_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] step_clamped;
    logic [WIDTH-1:0] load_clamped;
    logic             step_cycle;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   sum_down_wrap;

    always_comb begin
        step_clamped  = (i_step > MAX_VALUE) ? MAX_VALUE : i_step;
        load_clamped  = (i_load_value > MAX_VALUE) ? MAX_VALUE : i_load_value;
        step_cycle    = i_enable && (pre_q == PRE_LAST);
        sum_up        = {1'b0, value_q} + {1'b0, step_clamped};
        // Never exceeds 2*MAX_VALUE+1, so WIDTH+1 bits hold it exactly.
        sum_down_wrap = {1'b0, value_q} + MODULUS - {1'b0, step_clamped};
    end

    always_comb begin
        value_d = value_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (i_clear) begin
            value_d = RESET_VALUE;
            pre_d   = '0;
        end else if (i_load) begin
            value_d = load_clamped;
            pre_d   = '0;
        end else if (step_cycle) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (i_up) begin
                if (sum_up > LIMIT) begin
                    wrap_d  = 1'b1;
                    value_d = SATURATE ? MAX_VALUE : WIDTH'(sum_up - MODULUS);
                end else begin
                    value_d = WIDTH'(sum_up);
                end
            end else begin
                if (step_clamped > value_q) begin
                    wrap_d  = 1'b1;
                    value_d = SATURATE ? '0 : WIDTH'(sum_down_wrap);
                end else begin
                    value_d = value_q - step_clamped;
                end
            end
        end else if (i_enable) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            value_q <= RESET_VALUE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_value  = value_q;
    assign o_tick   = tick_q;
    assign o_wrap   = wrap_q;
    assign o_at_max = (value_q == MAX_VALUE);
    assign o_at_min = (value_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: five instances with different parameters share
// one stimulus bus; each scenario task resets them all and checks its own instance.
module tb_updown_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        up;
    logic [15:0] step;
    logic        clear;
    logic        load;
    logic [15:0] load_value;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] full_value, wrap_value, sat_value, pre_value, ld_value;
    logic full_tick, full_wrap, full_max, full_min;
    logic wrap_tick, wrap_wrap, wrap_max, wrap_min;
    logic sat_tick, sat_wrap, sat_max, sat_min;
    logic pre_tick, pre_wrap, pre_max, pre_min;
    logic ld_tick, ld_wrap, ld_max, ld_min;

    always #5 clk = ~clk;

    updown_counter u_full (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_step(step),
        .i_clear(clear), .i_load(load), .i_load_value(load_value),
        .o_value(full_value), .o_tick(full_tick), .o_wrap(full_wrap),
        .o_at_max(full_max), .o_at_min(full_min)
    );

    updown_counter #(.WIDTH(16), .MAX_VALUE(16'd9), .SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_step(step),
        .i_clear(clear), .i_load(load), .i_load_value(load_value),
        .o_value(wrap_value), .o_tick(wrap_tick), .o_wrap(wrap_wrap),
        .o_at_max(wrap_max), .o_at_min(wrap_min)
    );

    updown_counter #(.WIDTH(16), .MAX_VALUE(16'd9), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_step(step),
        .i_clear(clear), .i_load(load), .i_load_value(load_value),
        .o_value(sat_value), .o_tick(sat_tick), .o_wrap(sat_wrap),
        .o_at_max(sat_max), .o_at_min(sat_min)
    );

    updown_counter #(.WIDTH(16), .PRESCALE(4)) u_pre (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_step(step),
        .i_clear(clear), .i_load(load), .i_load_value(load_value),
        .o_value(pre_value), .o_tick(pre_tick), .o_wrap(pre_wrap),
        .o_at_max(pre_max), .o_at_min(pre_min)
    );

    updown_counter #(.WIDTH(16), .MAX_VALUE(16'd1000), .RESET_VALUE(16'd5)) u_ld (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_step(step),
        .i_clear(clear), .i_load(load), .i_load_value(load_value),
        .o_value(ld_value), .o_tick(ld_tick), .o_wrap(ld_wrap),
        .o_at_max(ld_max), .o_at_min(ld_min)
    );

    // Advance one edge and settle 2 ns after it; outputs are sampled and inputs driven here.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        enable = 1'b0; up = 1'b1; step = 16'd1;
        clear = 1'b0; load = 1'b0; load_value = 16'd0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 10;
        if (full_value !== 16'd0) begin miscompares++; $display("FAIL reset_full_value: got %0d want 0", full_value); end
        if (full_tick !== 1'b0 || full_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_flags: tick=%b wrap=%b want 0 0", full_tick, full_wrap); end
        if (full_min !== 1'b1 || full_max !== 1'b0) begin miscompares++; $display("FAIL reset_full_decode: min=%b max=%b want 1 0", full_min, full_max); end
        if (ld_value !== 16'd5) begin miscompares++; $display("FAIL reset_ld_value: got %0d want 5", ld_value); end
        if (ld_min !== 1'b0 || ld_max !== 1'b0) begin miscompares++; $display("FAIL reset_ld_decode: min=%b max=%b want 0 0", ld_min, ld_max); end
        if (wrap_min !== 1'b1 || wrap_max !== 1'b0) begin miscompares++; $display("FAIL reset_wrap_decode: min=%b max=%b want 1 0", wrap_min, wrap_max); end
        if (sat_min !== 1'b1 || sat_max !== 1'b0) begin miscompares++; $display("FAIL reset_sat_decode: min=%b max=%b want 1 0", sat_min, sat_max); end
        if (pre_min !== 1'b1 || pre_max !== 1'b0) begin miscompares++; $display("FAIL reset_pre_decode: min=%b max=%b want 1 0", pre_min, pre_max); end
        if (sat_tick !== 1'b0 || sat_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flags: tick=%b wrap=%b want 0 0", sat_tick, sat_wrap); end
        if (ld_tick !== 1'b0 || ld_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_ld_flags: tick=%b wrap=%b want 0 0", ld_tick, ld_wrap); end
    endtask

    task automatic test_full_range();
        int val_err  = 0;
        int max_err  = 0;
        int tick_err = 0;
        int wrap_cnt = 0;
        int wrap_at  = -1;
        int expv;
        do_reset();
        enable = 1'b1; up = 1'b1; step = 16'd1;
        for (int k = 1; k <= 70000; k++) begin
            cycle();
            expv = k % 65536;
            if (full_value !== 16'(expv)) val_err++;
            if (full_max !== (expv == 65535)) max_err++;
            if (full_tick !== 1'b1) tick_err++;
            if (full_wrap === 1'b1) begin wrap_cnt++; wrap_at = k; end
        end
        vectors += 6;
        if (val_err != 0) begin miscompares++; $display("FAIL full_value_errors: got %0d cycles wrong want 0", val_err); end
        if (max_err != 0) begin miscompares++; $display("FAIL full_at_max_errors: got %0d want 0", max_err); end
        if (tick_err != 0) begin miscompares++; $display("FAIL full_tick_errors: got %0d want 0", tick_err); end
        if (wrap_cnt != 1) begin miscompares++; $display("FAIL full_wrap_count: got %0d want 1", wrap_cnt); end
        if (wrap_at != 65536) begin miscompares++; $display("FAIL full_wrap_cycle: got %0d want 65536", wrap_at); end
        if (full_value !== 16'd4464) begin miscompares++; $display("FAIL full_final_value: got %0d want 4464", full_value); end
    endtask

    task automatic test_wrap();
        logic [15:0] ev [4];
        logic        ew [4];
        ev = '{16'd3, 16'd6, 16'd9, 16'd2};
        ew = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        enable = 1'b1; up = 1'b1; step = 16'd3;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors += 2;
            if (wrap_value !== ev[i]) begin miscompares++; $display("FAIL wrap_up_value[%0d]: got %0d want %0d", i, wrap_value, ev[i]); end
            if (wrap_wrap !== ew[i] || wrap_tick !== 1'b1) begin miscompares++; $display("FAIL wrap_up_flags[%0d]: wrap=%b tick=%b want %b 1", i, wrap_wrap, wrap_tick, ew[i]); end
        end
        up = 1'b0;
        cycle();
        vectors += 2;
        if (wrap_value !== 16'd9) begin miscompares++; $display("FAIL wrap_down_value: got %0d want 9", wrap_value); end
        if (wrap_wrap !== 1'b1) begin miscompares++; $display("FAIL wrap_down_flag: got %b want 1", wrap_wrap); end
    endtask

    task automatic test_step_clamp();
        do_reset();
        enable = 1'b1; up = 1'b1; step = 16'hFFFF;
        cycle();
        vectors += 3;
        if (wrap_value !== 16'd9) begin miscompares++; $display("FAIL clamp_first_value: got %0d want 9", wrap_value); end
        if (wrap_wrap !== 1'b0) begin miscompares++; $display("FAIL clamp_first_wrap: got %b want 0", wrap_wrap); end
        cycle();
        if (wrap_value !== 16'd8 || wrap_wrap !== 1'b1) begin miscompares++; $display("FAIL clamp_second: value=%0d wrap=%b want 8 1", wrap_value, wrap_wrap); end
        step = 16'd0;
        cycle();
        vectors += 2;
        if (wrap_value !== 16'd8 || wrap_wrap !== 1'b0 || wrap_tick !== 1'b1) begin miscompares++; $display("FAIL zero_step: value=%0d wrap=%b tick=%b want 8 0 1", wrap_value, wrap_wrap, wrap_tick); end
        enable = 1'b0;
        cycle();
        if (wrap_value !== 16'd8 || wrap_tick !== 1'b0) begin miscompares++; $display("FAIL disabled_hold: value=%0d tick=%b want 8 0", wrap_value, wrap_tick); end
    endtask

    task automatic test_saturate();
        logic [15:0] ev [4];
        logic        ew [4];
        logic [15:0] dv [3];
        logic        dw [3];
        ev = '{16'd4, 16'd8, 16'd9, 16'd9};
        ew = '{1'b0, 1'b0, 1'b1, 1'b1};
        dv = '{16'd4, 16'd0, 16'd0};
        dw = '{1'b0, 1'b1, 1'b1};
        do_reset();
        enable = 1'b1; up = 1'b1; step = 16'd4;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors += 3;
            if (sat_value !== ev[i]) begin miscompares++; $display("FAIL sat_up_value[%0d]: got %0d want %0d", i, sat_value, ev[i]); end
            if (sat_wrap !== ew[i] || sat_tick !== 1'b1) begin miscompares++; $display("FAIL sat_up_flags[%0d]: wrap=%b tick=%b want %b 1", i, sat_wrap, sat_tick, ew[i]); end
            if (sat_max !== (ev[i] == 16'd9)) begin miscompares++; $display("FAIL sat_at_max[%0d]: got %b want %b", i, sat_max, (ev[i] == 16'd9)); end
        end
        up = 1'b0; step = 16'd5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors += 3;
            if (sat_value !== dv[i]) begin miscompares++; $display("FAIL sat_down_value[%0d]: got %0d want %0d", i, sat_value, dv[i]); end
            if (sat_wrap !== dw[i]) begin miscompares++; $display("FAIL sat_down_wrap[%0d]: got %b want %b", i, sat_wrap, dw[i]); end
            if (sat_min !== (dv[i] == 16'd0)) begin miscompares++; $display("FAIL sat_at_min[%0d]: got %b want %b", i, sat_min, (dv[i] == 16'd0)); end
        end
    endtask

    task automatic test_prescale();
        logic        en [9];
        logic        et [9];
        logic [15:0] ev [9];
        en = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ev = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
        do_reset();
        up = 1'b1; step = 16'd1;
        for (int i = 0; i < 9; i++) begin
            enable = en[i];
            cycle();
            vectors += 2;
            if (pre_tick !== et[i]) begin miscompares++; $display("FAIL prescale_tick[%0d]: got %b want %b", i, pre_tick, et[i]); end
            if (pre_value !== ev[i]) begin miscompares++; $display("FAIL prescale_value[%0d]: got %0d want %0d", i, pre_value, ev[i]); end
        end
    endtask

    task automatic test_load_clear();
        do_reset();
        enable = 1'b1; up = 1'b1; step = 16'd1;
        load = 1'b1; load_value = 16'hFFFF;
        cycle();
        vectors += 3;
        if (ld_value !== 16'd1000) begin miscompares++; $display("FAIL load_clamp_value: got %0d want 1000", ld_value); end
        if (ld_tick !== 1'b0 || ld_wrap !== 1'b0) begin miscompares++; $display("FAIL load_flags: tick=%b wrap=%b want 0 0", ld_tick, ld_wrap); end
        if (ld_max !== 1'b1) begin miscompares++; $display("FAIL load_at_max: got %b want 1", ld_max); end
        clear = 1'b1;
        cycle();
        vectors += 2;
        if (ld_value !== 16'd5) begin miscompares++; $display("FAIL clear_over_load_value: got %0d want 5", ld_value); end
        if (ld_tick !== 1'b0 || ld_wrap !== 1'b0) begin miscompares++; $display("FAIL clear_flags: tick=%b wrap=%b want 0 0", ld_tick, ld_wrap); end
        clear = 1'b0; load_value = 16'd123;
        cycle();
        vectors += 2;
        if (ld_value !== 16'd123) begin miscompares++; $display("FAIL load_value_123: got %0d want 123", ld_value); end
        load = 1'b0;
        cycle();
        if (ld_value !== 16'd124 || ld_tick !== 1'b1) begin miscompares++; $display("FAIL step_after_load: value=%0d tick=%b want 124 1", ld_value, ld_tick); end
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1'b1; load_value = 16'd36;
        cycle();
        load = 1'b0;
        enable = 1'b1; up = 1'b1; step = 16'd1;
        for (int i = 0; i < 4; i++) cycle();
        vectors += 1;
        if (pre_value !== 16'd37 || pre_tick !== 1'b1) begin miscompares++; $display("FAIL pre_reset_state: value=%0d tick=%b want 37 1", pre_value, pre_tick); end
        #1;
        reset = 1'b1;
        #1;
        vectors += 3;
        if (pre_value !== 16'd0) begin miscompares++; $display("FAIL async_reset_value: got %0d want 0", pre_value); end
        if (pre_tick !== 1'b0 || pre_wrap !== 1'b0) begin miscompares++; $display("FAIL async_reset_flags: tick=%b wrap=%b want 0 0", pre_tick, pre_wrap); end
        if (ld_value !== 16'd5) begin miscompares++; $display("FAIL async_reset_ld_value: got %0d want 5", ld_value); end
        cycle();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            vectors += 1;
            if (pre_value !== ((i == 4) ? 16'd1 : 16'd0) || pre_tick !== (i == 4)) begin
                miscompares++;
                $display("FAIL resume_after_reset[%0d]: value=%0d tick=%b want %0d %b", i, pre_value, pre_tick, (i == 4) ? 1 : 0, (i == 4));
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b1; step = 16'd1;
        clear = 1'b0; load = 1'b0; load_value = 16'd0;
        test_reset();
        test_wrap();
        test_step_clamp();
        test_saturate();
        test_prescale();
        test_load_clear();
        test_async_reset();
        test_full_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
